data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between NUM_REQ requesters (port 0 = core load/store stage, port 1 = DMA/debug loader).
- Round-robin arbitration with valid/ready request and response handshakes. Latches one request and drives the memory address, write data, access size and write enable for exactly one cycle.
- Captures the combinational read data and returns it with a per-access range error flag.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- MEM_BYTES, 101, size of the memory in bytes; the valid byte range is 0..MEM_BYTES-1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  [NUM_REQ-1:0]  request present.
- req_ready  out  [NUM_REQ-1:0]  request accepted this edge (one-hot or zero).
- req_we  in  [NUM_REQ-1:0]  1 = store, 0 = load.
- req_size  in  [NUM_REQ-1:0][2:0]  access code LB_SB/LH_SH/LW_SW/LBU/LHU.
- req_addr  in  [NUM_REQ-1:0][31:0]  byte address.
- req_wdata  in  [NUM_REQ-1:0][31:0]  store data, little-endian.
- rsp_valid  out  [NUM_REQ-1:0]  response for the owning requester.
- rsp_ready  in  [NUM_REQ-1:0]  requester takes the response.
- rsp_rdata  out  32  load data, shared by all requesters.
- rsp_err  out  1  out-of-range access or write to address 0.
- addr_mem  out  32  to the memory.
- wdata_mem  out  32  to the memory.
- rd_wr_mem  out  3  to the memory.
- mem_wr  out  1  to the memory.
- rdata_mem  in  32  from the memory (combinational read).

Behaviour:
- States:
  - IDLE: no access outstanding.
  - ACCESS: memory is being driven, always exactly 1 cycle.
  - RESP: response is held for its owner.
- Reset (asynchronous, reset=0): state=IDLE, RR pointer=0. req_ready, rsp_valid, rsp_rdata, rsp_err, addr_mem, wdata_mem, rd_wr_mem and mem_wr are all 0.
- Reset mid-ACCESS aborts the access. A pending response is discarded and no response is produced.
- Arbitration:
  - Candidates are the requesters with req_valid set.
  - The winner is the first candidate at or after the RR pointer, searching modulo NUM_REQ.
  - After each accept, pointer = winner+1 mod NUM_REQ.
- req_ready[winner]=1 only when the state is IDLE, or RESP with rsp_ready of the owner high in the same cycle. It is combinational from req_valid, state and the pointer.
- On accept (posedge):
  - Latch owner, we, size, addr and wdata.
  - Compute err: addr+nbytes > MEM_BYTES, where nbytes = 1 for LB_SB/LBU, 2 for LH_SH/LHU and 4 for LW_SW. Compute with a 33-bit sum so there is no wrap. Also set err for a store to addr 0.
  - Go to ACCESS.
- ACCESS:
  - addr_mem, wdata_mem and rd_wr_mem come from the latch.
  - mem_wr = we & ~err for the entire cycle, so the memory's negedge write lands mid-cycle.
  - At the next posedge: rsp_rdata = err ? 0 : (we ? 0 : rdata_mem), rsp_err = err, rsp_valid[owner]=1, and the state goes to RESP.
- Latency: accept at edge N produces rsp_valid at edge N+1. With rsp_ready held high, one access completes every 2 cycles.
- RESP:
  - Outputs are held stable until rsp_ready[owner].
  - If rsp_ready is high and a request is accepted in the same cycle, go to ACCESS.
  - If rsp_ready is high and no request is accepted, go to IDLE.
  - Otherwise stay in RESP.
  - rsp_ready of non-owners is ignored.
- Outside ACCESS, mem_wr=0. addr_mem, wdata_mem and rd_wr_mem hold their last values (no toggling).
- Requester inputs need only be stable during the cycle in which req_ready is high.
- Unknown size codes behave as LB_SB (nbytes=1), matching the memory's default decode.

Decomposition:
- Shared package (packages):
  - arb_state_t enum {IDLE, ACCESS, RESP}.
  - MEM_BYTES_DEFAULT.
  - Function size_bytes(logic [2:0]) returning 1/2/4, reusing the existing LB_SB/LH_SH/LW_SW/LBU/LHU constants.
- One sub-module, rr_arbiter: the round-robin pointer register plus the one-hot grant logic, parameterised by NUM_REQ. The FSM and the request/response registers stay in data_mem_arbiter.

Test Plan:
- After reset release: p0 store LW_SW addr=8 wdata=0xDEADBEEF, then p0 load LW_SW addr=8 → rsp_valid[0] one cycle after each accept. Load rsp_rdata=0xDEADBEEF, rsp_err=0. mem_wr high exactly one cycle.
- Both requesters hold req_valid with loads to addrs 4 and 12 → accept order p0,p1,p0,p1; rsp_valid alternates [0],[1]. The RR pointer is verified after each accept.
- p1 load LB_SB addr=20 where the byte is 0x80 → rsp_rdata=0xFFFFFF80. Same address with LBU → 0x00000080. LHU addr=20 with bytes 0x80,0x12 → 0x00001280.
- p0 store LW_SW addr=99 → rsp_err=1, mem_wr never asserted, memory bytes 99..100 unchanged. Store LB_SB addr=0 → rsp_err=1. Load LW_SW addr=97 → rsp_err=0.
- Response backpressure: hold rsp_ready[0]=0 for 3 cycles while p1 requests → req_ready stays 0 and the rsp outputs stay stable. Raising rsp_ready[0] accepts p1 the same cycle; p1's response follows at edge N+1.
- Assert reset=0 asynchronously mid-ACCESS of a store to addr 16 → all outputs 0 immediately, no response after release, RR pointer=0.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared types, access-size codes and helpers for the data memory arbiter
package data_mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    localparam int MEM_BYTES_DEFAULT = 101;
    localparam logic [2:0] LB_SB = 3'b000;
    localparam logic [2:0] LH_SH = 3'b001;
    localparam logic [2:0] LW_SW = 3'b010;
    localparam logic [2:0] LBU   = 3'b100;
    localparam logic [2:0] LHU   = 3'b101;
    // Unknown codes fall back to a single byte, like the memory's decode
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        return (size == LW_SW) ? 3'd4 : (size == LH_SH || size == LHU) ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pointer and one-hot grant, searching from the pointer modulo NUM_REQ
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      winner
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic          found;
    always_comb begin
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                grant[idx] = enable;
                winner     = idx;
                found      = 1'b1;
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ptr <= '0;
        else if (|grant)
            ptr <= PW'((int'(winner) + 1) % NUM_REQ);
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of the single-port data memory with one-cycle accesses
// and held responses carrying load data and a range-error flag.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ-1:0][2:0]  req_size,
    input  logic [NUM_REQ-1:0][31:0] req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [31:0]            addr_mem,
    output logic [31:0]            wdata_mem,
    output logic [2:0]             rd_wr_mem,
    output logic                   mem_wr,
    input  logic [31:0]            rdata_mem
);
    localparam int PW = $clog2(NUM_REQ);
    arb_state_t         state, state_nx;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      winner, owner;
    logic               accept_en, we, err, nx_err;
    logic [2:0]         size;
    logic [31:0]        addr, wdata;
    assign accept_en = (state == IDLE) || (state == RESP && rsp_ready[owner]);
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .enable   (accept_en),
        .grant    (grant),
        .winner   (winner)
    );
    assign req_ready = grant;
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign nx_err = ({1'b0, req_addr[winner]} + 33'(size_bytes(req_size[winner])) > 33'(MEM_BYTES))
                  || (req_we[winner] && req_addr[winner] == 32'd0);
    assign addr_mem  = addr;
    assign wdata_mem = wdata;
    assign rd_wr_mem = size;
    always_comb begin
        state_nx = (state == ACCESS) ? RESP :
                   (|grant) ? ACCESS :
                   (state == RESP && rsp_ready[owner]) ? IDLE : state;
        mem_wr   = (state == ACCESS) && we && !err;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= '0;
            we        <= 1'b0;
            err       <= 1'b0;
            size      <= '0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (|grant) begin
                owner <= winner;
                we    <= req_we[winner];
                size  <= req_size[winner];
                addr  <= req_addr[winner];
                wdata <= req_wdata[winner];
                err   <= nx_err;
            end
            if (state == ACCESS) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_rdata <= (err || we) ? 32'd0 : rdata_mem;
                rsp_err   <= err;
            end else if (state == RESP && rsp_ready[owner]) begin
                rsp_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed table-driven bench with a byte-array memory model
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;
    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_ready = 2'b11;
    logic [1:0][2:0]  req_size = '0;
    logic [1:0][31:0] req_addr = '0, req_wdata = '0;
    logic [31:0]      rsp_rdata, addr_mem, wdata_mem, rdata_mem;
    logic             rsp_err, mem_wr;
    logic [2:0]       rd_wr_mem;
    int               n_checks = 0, n_fail = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(.NUM_REQ(2), .MEM_BYTES(101)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .addr_mem(addr_mem), .wdata_mem(wdata_mem), .rd_wr_mem(rd_wr_mem), .mem_wr(mem_wr),
        .rdata_mem(rdata_mem)
    );

    logic [7:0] mem [0:127];
    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        b0 = mem[addr_mem[6:0]];
        b1 = mem[addr_mem[6:0] + 7'd1];
        b2 = mem[addr_mem[6:0] + 7'd2];
        b3 = mem[addr_mem[6:0] + 7'd3];
        case (rd_wr_mem)
            LH_SH:   rdata_mem = {{16{b1[7]}}, b1, b0};
            LW_SW:   rdata_mem = {b3, b2, b1, b0};
            LBU:     rdata_mem = {24'd0, b0};
            LHU:     rdata_mem = {16'd0, b1, b0};
            default: rdata_mem = {{24{b0[7]}}, b0};
        endcase
    end
    always @(negedge clock) begin
        if (mem_wr) begin
            mem[addr_mem[6:0]] = wdata_mem[7:0];
            if (rd_wr_mem == LH_SH || rd_wr_mem == LHU || rd_wr_mem == LW_SW)
                mem[addr_mem[6:0] + 7'd1] = wdata_mem[15:8];
            if (rd_wr_mem == LW_SW) begin
                mem[addr_mem[6:0] + 7'd2] = wdata_mem[23:16];
                mem[addr_mem[6:0] + 7'd3] = wdata_mem[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        wr;
    } vec_t;
    vec_t vecs[10];

    task automatic run_vec(input int i, input vec_t v);
        int n;
        @(negedge clock);
        req_valid = '0;
        req_valid[v.port] = 1'b1;
        req_we[v.port]    = v.we;
        req_size[v.port]  = v.size;
        req_addr[v.port]  = v.addr;
        req_wdata[v.port] = v.wdata;
        #1;
        n = 0;
        while (req_ready !== 2'(1 << v.port) && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(1 << v.port));
        @(posedge clock); #1;
        req_valid = '0;
        chk($sformatf("v%0d_ptr", i), 32'(dut.u_arb.ptr), 32'((v.port + 1) % 2));
        chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr), 32'(v.wr));
        chk($sformatf("v%0d_early_rsp", i), 32'(rsp_valid), 32'd0);
        @(posedge clock); #1;
        chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(1 << v.port));
        chk($sformatf("v%0d_rdata", i), rsp_rdata, v.rdata);
        chk($sformatf("v%0d_err", i), 32'(rsp_err), 32'(v.err));
        chk($sformatf("v%0d_wr_off", i), 32'(mem_wr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[0] = 8'h77;
        {mem[7], mem[6], mem[5], mem[4]}     = 32'h44332211;
        {mem[15], mem[14], mem[13], mem[12]} = 32'h88776655;
        mem[20] = 8'h80; mem[21] = 8'h12;
        mem[97] = 8'h01; mem[98] = 8'h02; mem[99] = 8'hA5; mem[100] = 8'h5A;

        vecs[0] = '{0, 1'b1, LW_SW,  32'd8,   32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1};
        vecs[1] = '{0, 1'b0, LW_SW,  32'd8,   32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{1, 1'b0, LB_SB,  32'd20,  32'h0,        32'hFFFFFF80, 1'b0, 1'b0};
        vecs[3] = '{1, 1'b0, LBU,    32'd20,  32'h0,        32'h00000080, 1'b0, 1'b0};
        vecs[4] = '{1, 1'b0, LHU,    32'd20,  32'h0,        32'h00001280, 1'b0, 1'b0};
        vecs[5] = '{0, 1'b1, LW_SW,  32'd99,  32'h11223344, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{0, 1'b1, LB_SB,  32'd0,   32'h000000AA, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{0, 1'b0, LW_SW,  32'd97,  32'h0,        32'h5AA50201, 1'b0, 1'b0};
        vecs[8] = '{0, 1'b0, 3'b111, 32'd100, 32'h0,        32'h0000005A, 1'b0, 1'b0};
        vecs[9] = '{1, 1'b0, LH_SH,  32'd100, 32'h0,        32'h00000000, 1'b1, 1'b0};

        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_if", addr_mem | wdata_mem | 32'(rd_wr_mem) | 32'(mem_wr), 32'd0);
        chk("rst_ptr", 32'(dut.u_arb.ptr), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
        chk("mem99_kept", 32'(mem[99]), 32'hA5);
        chk("mem100_kept", 32'(mem[100]), 32'h5A);
        chk("mem0_kept", 32'(mem[0]), 32'h77);

        // both requesters contend: alternation from pointer 0
        @(negedge clock);
        req_valid = 2'b11; req_we = '0;
        req_size[0] = LW_SW; req_size[1] = LW_SW;
        req_addr[0] = 32'd4; req_addr[1] = 32'd12;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % 2)));
            @(posedge clock); #1;
            chk($sformatf("rr%0d_ptr", k), 32'(dut.u_arb.ptr), 32'((k + 1) % 2));
            if (k == 3) req_valid = '0;
            @(posedge clock); #1;
            chk($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'(1 << (k % 2)));
            chk($sformatf("rr%0d_rdata", k), rsp_rdata, (k % 2) ? 32'h88776655 : 32'h44332211);
        end
        repeat (2) @(posedge clock);

        // response backpressure on port 0 while port 1 waits
        @(negedge clock);
        req_addr[0] = 32'd8;
        req_valid = 2'b01;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        chk("bp_access_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", i), rsp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp%0d_err", i), 32'(rsp_err), 32'd0);
            @(posedge clock); #1;
        end
        rsp_ready = 2'b11;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd2);
        @(posedge clock); #1;
        req_valid = '0;
        chk("bp_p1_access_rsp", 32'(rsp_valid), 32'd0);
        chk("bp_p1_ptr", 32'(dut.u_arb.ptr), 32'd0);
        @(posedge clock); #1;
        chk("bp_p1_rsp_valid", 32'(rsp_valid), 32'd2);
        chk("bp_p1_rdata", rsp_rdata, 32'h88776655);
        repeat (2) @(posedge clock);

        // asynchronous reset in the middle of a store
        @(negedge clock);
        req_valid = 2'b01; req_we[0] = 1'b1; req_size[0] = LW_SW;
        req_addr[0] = 32'd16; req_wdata[0] = 32'hCAFEF00D;
        #1;
        chk("ar_ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        chk("ar_mem_wr", 32'(mem_wr), 32'd1);
        chk("ar_ptr_pre", 32'(dut.u_arb.ptr), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        req_valid = '0;
        chk("ar_mem_if", addr_mem | wdata_mem | 32'(rd_wr_mem) | 32'(mem_wr), 32'd0);
        chk("ar_rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
        chk("ar_rdata", rsp_rdata, 32'd0);
        chk("ar_ptr", 32'(dut.u_arb.ptr), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk($sformatf("ar_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        chk("ar_mem16", {mem[19], mem[18], mem[17], mem[16]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
